// File: rtl/tt_io_pkg.sv
// Shared constants and types for the ui_in input-conditioning path.
package tt_io_pkg;

    localparam int TT_IO_WIDTH           = 8;
    localparam int TT_SYNC_STAGES        = 2;
    localparam int TT_DEBOUNCE_CYCLES    = 16;

    typedef logic [TT_IO_WIDTH-1:0] io_vec_t;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } deb_state_e;

endpackage

// File: rtl/tt_debounce_bit.sv
// Single-bit synchroniser, debounce counter, clean level and edge pulses.
module tt_debounce_bit
    import tt_io_pkg::*;
#(
    parameter int SYNC_STAGES     = TT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = TT_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_ena,
    input  logic i_raw,
    output logic o_clean,
    output logic o_rise,
    output logic o_fall,
    output logic o_accept
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_count;
    logic                   r_clean;
    logic                   r_rise;
    logic                   r_fall;

    logic [CNT_W-1:0]       w_count_nxt;
    logic                   w_clean_nxt;
    logic                   w_synced;
    logic                   w_diff;
    logic                   w_accept;
    deb_state_e             w_state;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign w_diff   = w_synced ^ r_clean;
    // The counter value itself is the state: zero means no pending change.
    assign w_state  = (r_count == '0) ? ST_STABLE : ST_COUNTING;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync  <= '0;
            r_count <= '0;
            r_clean <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_raw};
            r_count <= w_count_nxt;
            r_clean <= w_clean_nxt;
            r_rise  <= w_accept & w_synced;
            r_fall  <= w_accept & ~w_synced;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        w_clean_nxt = r_clean;
        unique case (w_state)
            ST_STABLE: begin
                if (w_diff && i_ena) begin
                    w_count_nxt = CNT_W'(1);
                end
            end
            ST_COUNTING: begin
                if (!w_diff) begin
                    w_count_nxt = '0;
                end else if (i_ena) begin
                    if (r_count == CNT_MAX) begin
                        w_count_nxt = '0;
                        w_clean_nxt = w_synced;
                    end else begin
                        w_count_nxt = r_count + 1'b1;
                    end
                end
            end
            default: w_count_nxt = '0;
        endcase
    end

    always_comb begin
        w_accept = w_diff && i_ena && (r_count == CNT_MAX);
        o_accept = w_accept;
        o_clean  = r_clean;
        o_rise   = r_rise;
        o_fall   = r_fall;
    end

endmodule

// File: rtl/tt_input_debounce.sv
// Conditions the ui_in switches: per-bit sync + debounce, with edge pulses.
module tt_input_debounce
    import tt_io_pkg::*;
#(
    parameter int WIDTH           = TT_IO_WIDTH,
    parameter int SYNC_STAGES     = TT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = TT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    logic [WIDTH-1:0] w_accept;
    logic             r_changed;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        tt_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .i_clk    (clk),
            .i_rst_n  (rst_n),
            .i_ena    (ena),
            .i_raw    (raw_in[g]),
            .o_clean  (clean_out[g]),
            .o_rise   (rise[g]),
            .o_fall   (fall[g]),
            .o_accept (w_accept[g])
        );
    end

    // Registered from the same acceptance terms so it aligns with rise/fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_changed <= 1'b0;
        end else begin
            r_changed <= |w_accept;
        end
    end

    assign changed = r_changed;

endmodule

// File: tb/tb_tt_input_debounce.sv
// Self-checking bench for tt_input_debounce with a 4-cycle debounce window.
module tb_tt_input_debounce;
    import tt_io_pkg::*;

    localparam int W  = 8;
    localparam int SS = 2;
    localparam int DC = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b1;
    io_vec_t      raw_in = '0;
    io_vec_t      clean_out;
    io_vec_t      rise;
    io_vec_t      fall;
    logic         changed;

    int errors = 0;
    int checks = 0;

    tt_input_debounce #(
        .WIDTH           (W),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .raw_in    (raw_in),
        .clean_out (clean_out),
        .rise      (rise),
        .fall      (fall),
        .changed   (changed)
    );

    always #5 clk = ~clk;

    // Reference: raw passes through an SS-deep delay line; a bit is accepted
    // once it has disagreed with the clean level for DC enabled cycles in a row.
    io_vec_t m_sync [SS];
    int      m_run  [W];
    io_vec_t m_clean;
    io_vec_t m_rise;
    io_vec_t m_fall;
    logic    m_changed;

    function automatic io_vec_t accepts();
        io_vec_t a;
        a = '0;
        for (int b = 0; b < W; b++)
            a[b] = ena && (m_sync[SS-1][b] != m_clean[b])
                   && (m_run[b] == DC - 1);
        return a;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SS; i++) m_sync[i] <= '0;
            for (int b = 0; b < W; b++) m_run[b] <= 0;
            m_clean   <= '0;
            m_rise    <= '0;
            m_fall    <= '0;
            m_changed <= 1'b0;
        end else begin
            m_rise    <= '0;
            m_fall    <= '0;
            m_changed <= |accepts();
            for (int b = 0; b < W; b++) begin
                if (m_sync[SS-1][b] == m_clean[b]) begin
                    m_run[b] <= 0;
                end else if (ena) begin
                    if (m_run[b] == DC - 1) begin
                        m_run[b]   <= 0;
                        m_clean[b] <= ~m_clean[b];
                        m_rise[b]  <= ~m_clean[b];
                        m_fall[b]  <= m_clean[b];
                    end else begin
                        m_run[b] <= m_run[b] + 1;
                    end
                end
            end
            m_sync[0] <= raw_in;
            for (int i = 1; i < SS; i++) m_sync[i] <= m_sync[i-1];
        end
    end

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        io_vec_t ec, er;
        logic    ech;
        rst_n  = 1'b0;
        raw_in = 8'hFF;
        ena    = 1'b1;
        settle(2);
        checks++;
        if ({clean_out, rise, fall, changed} !== 25'd0) begin
            errors++;
            $display("FAIL reset_state got c=%h r=%h f=%h ch=%b want 0",
                     clean_out, rise, fall, changed);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            ec  = (k >= 6) ? 8'hFF : 8'h00;
            er  = (k == 6) ? 8'hFF : 8'h00;
            ech = (k == 6);
            checks++;
            if (clean_out !== ec || rise !== er || changed !== ech
                || fall !== 8'h00) begin
                errors++;
                $display("FAIL reset_latency k=%0d c=%h/%h r=%h/%h ch=%b/%b f=%h",
                         k, clean_out, ec, rise, er, changed, ech, fall);
            end
        end
    endtask

    task automatic test_glitch();
        raw_in = 8'h00;
        settle(10);
        checks++;
        if (clean_out !== 8'h00) begin
            errors++;
            $display("FAIL glitch_setup got %h want 00", clean_out);
        end
        raw_in[3] = 1'b1;
        settle(3);
        raw_in[3] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (clean_out[3] !== 1'b0 || rise !== 8'h00 || changed !== 1'b0) begin
                errors++;
                $display("FAIL glitch k=%0d c=%h r=%h ch=%b want 00/00/0",
                         k, clean_out, rise, changed);
            end
        end
    endtask

    task automatic test_fall();
        io_vec_t ec, ef;
        raw_in = 8'h01;
        settle(10);
        checks++;
        if (clean_out !== 8'h01) begin
            errors++;
            $display("FAIL fall_setup got %h want 01", clean_out);
        end
        raw_in[0] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            ec = (k >= 6) ? 8'h00 : 8'h01;
            ef = (k == 6) ? 8'h01 : 8'h00;
            checks++;
            if (clean_out !== ec || fall !== ef || rise !== 8'h00
                || changed !== (k == 6)) begin
                errors++;
                $display("FAIL fall_edge k=%0d c=%h/%h f=%h/%h r=%h ch=%b",
                         k, clean_out, ec, fall, ef, rise, changed);
            end
        end
    endtask

    task automatic test_freeze();
        raw_in[5] = 1'b1;
        settle(4);
        ena = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (clean_out !== 8'h00 || rise !== 8'h00 || changed !== 1'b0) begin
                errors++;
                $display("FAIL freeze_hold k=%0d c=%h r=%h ch=%b want 00/00/0",
                         k, clean_out, rise, changed);
            end
        end
        ena = 1'b1;
        @(negedge clk);
        checks++;
        if (clean_out !== 8'h00 || rise !== 8'h00) begin
            errors++;
            $display("FAIL freeze_early c=%h r=%h want 00/00", clean_out, rise);
        end
        @(negedge clk);
        checks++;
        if (clean_out !== 8'h20 || rise !== 8'h20 || changed !== 1'b1) begin
            errors++;
            $display("FAIL freeze_resume c=%h r=%h ch=%b want 20/20/1",
                     clean_out, rise, changed);
        end
        @(negedge clk);
        checks++;
        if (rise !== 8'h00 || changed !== 1'b0) begin
            errors++;
            $display("FAIL freeze_pulse_len r=%h ch=%b want 00/0", rise, changed);
        end
    endtask

    task automatic test_simultaneous();
        int pulses;
        raw_in = 8'h00;
        settle(10);
        raw_in = 8'hA5;
        pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (changed === 1'b1) pulses++;
            checks++;
            if (clean_out !== ((k >= 6) ? 8'hA5 : 8'h00)
                || rise !== ((k == 6) ? 8'hA5 : 8'h00)) begin
                errors++;
                $display("FAIL simul k=%0d c=%h r=%h", k, clean_out, rise);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL simul_changed got %0d pulses want 1", pulses);
        end
    endtask

    task automatic test_async_reset();
        raw_in = 8'hA1;
        settle(4);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({clean_out, rise, fall, changed} !== 25'd0) begin
            errors++;
            $display("FAIL async_reset c=%h r=%h f=%h ch=%b want 0",
                     clean_out, rise, fall, changed);
        end
        @(negedge clk);
        raw_in = 8'h04;
        rst_n  = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checks++;
            if (clean_out !== ((k >= 6) ? 8'h04 : 8'h00)
                || rise !== ((k == 6) ? 8'h04 : 8'h00)) begin
                errors++;
                $display("FAIL async_relatency k=%0d c=%h r=%h",
                         k, clean_out, rise);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            checks++;
            if (clean_out !== m_clean || rise !== m_rise
                || fall !== m_fall || changed !== m_changed) begin
                errors++;
                $display("FAIL random k=%0d c=%h/%h r=%h/%h f=%h/%h ch=%b/%b",
                         k, clean_out, m_clean, rise, m_rise,
                         fall, m_fall, changed, m_changed);
            end
            checks++;
            if ((rise & fall) !== 8'h00) begin
                errors++;
                $display("FAIL rise_fall_overlap k=%0d got %h want 00",
                         k, rise & fall);
            end
            for (int b = 0; b < W; b++)
                if ($urandom_range(9) == 0) raw_in[b] = ~raw_in[b];
            if ($urandom_range(15) == 0) raw_in = ~raw_in;
            ena = ($urandom_range(7) != 0);
        end
        ena = 1'b1;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_fall();
        test_freeze();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
